// File: rtl/fifo_word_packer.sv
// Drain stage for synchronous_fifo: pops PACK narrow entries and presents them
// as one wide word on a valid/ready stream; flush emits a partial word.
module fifo_word_packer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned CNT_W      = $clog2(PACK + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fifo_empty,
  output logic                       fifo_r_en,
  input  logic [DATA_WIDTH-1:0]      fifo_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [CNT_W-1:0]           out_count
);

  localparam int unsigned       WORD_W = DATA_WIDTH * PACK;
  localparam logic [CNT_W-1:0]  FULL   = CNT_W'(PACK);

  typedef enum logic {FILL, OUT} state_e;

  state_e                              state_q, state_n;
  logic [CNT_W-1:0]                    cnt_q, cnt_n;
  logic                                pend_q, pend_n;
  logic                                flush_req_q, flush_req_n;
  logic [PACK-1:0][DATA_WIDTH-1:0]     lanes_q, lanes_n;
  logic                                out_valid_n;
  logic [WORD_W-1:0]                   out_data_n;
  logic [CNT_W-1:0]                    out_count_n;

  // Next-state, lane capture and pop request
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    pend_n      = 1'b0;
    flush_req_n = flush_req_q | flush;
    lanes_n     = lanes_q;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_count_n = out_count;
    fifo_r_en   = 1'b0;

    case (state_q)
      FILL: begin
        // Reserve a lane for every pop still in flight so cnt never overruns PACK
        fifo_r_en = !fifo_empty && !flush_req_q
                    && ((cnt_q + CNT_W'(pend_q)) < FULL);
        pend_n    = fifo_r_en;

        if (pend_q) begin
          for (int unsigned i = 0; i < PACK; i++) begin
            if (CNT_W'(i) == cnt_q) begin
              lanes_n[i] = fifo_data;
            end
          end
          cnt_n = cnt_q + CNT_W'(1);
        end

        if (cnt_n == FULL) begin
          state_n = OUT;
        end else if (flush_req_q && !pend_q) begin
          if (cnt_q != '0) begin
            state_n = OUT;
          end else begin
            flush_req_n = flush;
          end
        end

        if (state_n == OUT) begin
          out_valid_n = 1'b1;
          out_data_n  = lanes_n;
          out_count_n = cnt_n;
        end
      end

      OUT: begin
        // A flush arriving in the accept cycle belongs to the word leaving now
        if (out_ready) begin
          state_n     = FILL;
          lanes_n     = '0;
          cnt_n       = '0;
          flush_req_n = 1'b0;
          out_valid_n = 1'b0;
          out_data_n  = '0;
          out_count_n = '0;
        end
      end
    endcase

    if (rst) begin
      fifo_r_en = 1'b0;
    end
  end

  // State and output registers; reset discards partial lanes and in-flight pop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      flush_req_q <= 1'b0;
      lanes_q     <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_count   <= '0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      pend_q      <= pend_n;
      flush_req_q <= flush_req_n;
      lanes_q     <= lanes_n;
      out_valid   <= out_valid_n;
      out_data    <= out_data_n;
      out_count   <= out_count_n;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a queue-based FIFO feeds the DUT and
// a byte-accumulating model predicts every word the DUT must emit.
module tb_fifo_word_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned CW = $clog2(PK + 1);
  localparam int unsigned WW = DW * PK;

  typedef struct {
    logic [WW-1:0] data;
    logic [CW-1:0] count;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_data;
  logic [CW-1:0] out_count;

  exp_t          exp_q[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] acc[$];
  int            n_vec;
  int            n_err;
  int            pop_count;
  int            valid_cycles;
  int            ready_mode;

  fifo_word_packer #(.DATA_WIDTH(DW), .PACK(PK)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the words are simply the popped byte stream cut into groups of PK
  function automatic void emit_acc();
    exp_t e;
    e.data = '0;
    foreach (acc[i]) e.data[i*DW +: DW] = acc[i];
    e.count = CW'(acc.size());
    exp_q.push_back(e);
    acc.delete();
  endfunction

  function automatic void model_pop(input logic [DW-1:0] b);
    acc.push_back(b);
    if (acc.size() == PK) emit_acc();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    fq.push_back(b);
  endtask

  task automatic wait_idle(input string name, input bit need_drain, input int budget);
    int n;
    int settle;
    n = 0;
    settle = 0;
    while ((fq.size() != 0 || (need_drain && exp_q.size() != 0) || settle < 3) && n < budget) begin
      tick();
      n++;
      if (fq.size() == 0) settle++;
      else settle = 0;
    end
    n_vec++;
    if (n >= budget) begin
      n_err++;
      $display("FAIL %s_timeout: fifo=%0d words_pending=%0d after %0d cycles, required 0", name,
               fq.size(), exp_q.size(), n);
    end
  endtask

  task automatic do_flush();
    if (acc.size() > 0) emit_acc();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // FIFO model: a pop sampled in cycle N delivers its entry in cycle N+1
  initial begin
    logic do_pop;
    fifo_empty = 1'b1;
    fifo_data  = '0;
    forever begin
      @(negedge clk);
      do_pop = fifo_r_en;
      if (do_pop) begin
        n_vec++;
        if (fifo_empty) begin
          n_err++;
          $display("FAIL underflow: fifo_r_en=1 with fifo_empty=1, required fifo_r_en=0");
          do_pop = 1'b0;
        end
      end
      @(posedge clk);
      #2;
      if (do_pop && fq.size() > 0) begin
        fifo_data = fq.pop_front();
        pop_count++;
        model_pop(fifo_data);
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // Consumer ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (ready_mode == 1);
    end
  end

  // Monitor: hold stability, no pops while presenting, words against scoreboard
  initial begin
    logic          pv, pr;
    logic [WW-1:0] pd;
    logic [CW-1:0] pc;
    exp_t          e;
    pv = 1'b0; pr = 1'b0; pd = '0; pc = '0;
    forever begin
      @(negedge clk);
      if (pv && !pr) begin
        n_vec++;
        if (!out_valid || out_data !== pd || out_count !== pc) begin
          n_err++;
          $display("FAIL hold: valid=%0b data=%0h count=%0d, required valid=1 data=%0h count=%0d",
                   out_valid, out_data, out_count, pd, pc);
        end
      end
      if (out_valid) begin
        valid_cycles++;
        n_vec++;
        if (fifo_r_en !== 1'b0) begin
          n_err++;
          $display("FAIL pop_in_out: fifo_r_en=%0b while out_valid, required 0", fifo_r_en);
        end
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_word: got data=%0h count=%0d, required no word", out_data, out_count);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_count !== e.count) begin
            n_err++;
            $display("FAIL word: got data=%0h count=%0d, required data=%0h count=%0d",
                     out_data, out_count, e.data, e.count);
          end
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pc = out_count;
    end
  end

  initial begin
    int n;
    n_vec = 0; n_err = 0; pop_count = 0; valid_cycles = 0;
    ready_mode = 1;
    out_ready  = 1'b1;
    rst        = 1'b1;
    flush      = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_fifo_r_en", fifo_r_en, 0);
    rst = 1'b0;

    // Single full word
    pop_count = 0; valid_cycles = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_idle("t1", 1'b1, 200);
    chk("t1_pops", pop_count, 4);
    chk("t1_valid_cycles", valid_cycles, 1);

    // Backpressure holds the first word and stops popping
    ready_mode = 0; out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    repeat (10) tick();
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 32'h04030201);
    chk("t2_count", out_count, 4);
    ready_mode = 1; out_ready = 1'b1;
    wait_idle("t2", 1'b1, 200);

    // Partial word through flush, then a normal word
    push(8'hAA); push(8'hBB);
    wait_idle("t3a", 1'b1, 200);
    do_flush();
    wait_idle("t3b", 1'b1, 200);
    for (int i = 0; i < 4; i++) push(DW'(8'hC0 + i));
    wait_idle("t3c", 1'b1, 200);

    // Flush with nothing accumulated must emit nothing
    do_flush();
    repeat (5) tick();
    chk("t4_no_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) push(DW'(8'hD0 + i));
    wait_idle("t4", 1'b1, 200);

    // Starved FIFO mid-word: no early output
    push(8'h11);
    repeat (20) tick();
    chk("t5_no_early", out_valid, 0);
    push(8'h22); push(8'h33); push(8'h44);
    wait_idle("t5", 1'b1, 200);

    // Reset with two lanes filled and a pop in flight
    push(8'h55); push(8'h66); push(8'h77);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_out_count", out_count, 0);
    chk("t6_fifo_r_en", fifo_r_en, 0);
    rst = 1'b0;
    acc.delete();
    for (int i = 0; i < 4; i++) push(DW'(8'hE0 + i));
    wait_idle("t6", 1'b1, 200);

    // Random bursts with random backpressure, flushed when the FIFO runs dry
    ready_mode = 2;
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(1, 13);
      for (int j = 0; j < n; j++) begin
        push(DW'($urandom));
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_idle("rnd_fill", 1'b0, 500);
      do_flush();
      wait_idle("rnd_drain", 1'b1, 500);
    end
    ready_mode = 1;
    repeat (5) tick();
    chk("final_pending", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
